// File: rtl/sru_sc_pkg.sv
// sru_sc_pkg: shared slow-control definitions for the SRU SC arbiters.
`default_nettype none

package sru_sc_pkg;

  localparam int SC_PORT_W = 16;
  localparam int SC_DATA_W = 32;

  localparam logic [SC_DATA_W-1:0] SC_ERR_TMO = 32'h8000_0001;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BUSY = 3'd1,
    ST_ACK  = 3'd2,
    ST_TMO  = 3'd3,
    ST_GAP  = 3'd4
  } sc_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; search starts at (last+1) mod NREQ.
`default_nettype none

module rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      last,
  output logic [2:0]      gnt_idx,
  output logic            gnt_vld
);

  int cand;

  // Walk from the farthest candidate to the nearest so the nearest hit is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = 0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = (int'(last) + k) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (j == cand && req[j]) begin
          gnt_idx = 3'(j);
          gnt_vld = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/flash_sc_arbiter.sv
// flash_sc_arbiter: whole-transaction round-robin sharing of the flash SC port,
// with per-transaction timeout and a forced idle gap between transactions.
`default_nettype none

module flash_sc_arbiter
  import sru_sc_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TMO_CYC = 1_000_000,
  parameter int GAP_CYC = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SC_PORT_W*NREQ-1:0] req_port,
  input  logic [SC_DATA_W*NREQ-1:0] req_data,
  input  logic [SC_DATA_W*NREQ-1:0] req_addr,
  input  logic [SC_DATA_W*NREQ-1:0] req_subaddr,
  input  logic [NREQ-1:0]           req_op,
  input  logic [NREQ-1:0]           req_frame,
  input  logic [NREQ-1:0]           req_wr,
  output logic [NREQ-1:0]           req_ack,
  output logic [SC_DATA_W-1:0]      rply_data,
  output logic [SC_DATA_W-1:0]      rply_error,
  output logic [SC_PORT_W-1:0]      flash_sc_port,
  output logic [SC_DATA_W-1:0]      flash_sc_data,
  output logic [SC_DATA_W-1:0]      flash_sc_addr,
  output logic [SC_DATA_W-1:0]      flash_sc_subaddr,
  output logic                      flash_sc_op,
  output logic                      flash_sc_frame,
  output logic                      flash_sc_wr,
  input  logic                      flash_sc_ack,
  input  logic [SC_DATA_W-1:0]      flash_sc_rply_data,
  input  logic [SC_DATA_W-1:0]      flash_sc_rply_error,
  output logic [2:0]                owner,
  output logic                      busy,
  output logic [15:0]               tmo_cnt
);

  sc_state_t state, state_nxt;
  logic [2:0]  last;
  logic [31:0] cnt;
  logic [2:0]  gnt_idx;
  logic        gnt_vld;

  logic [SC_PORT_W-1:0] own_port;
  logic [SC_DATA_W-1:0] own_data, own_addr, own_sub;
  logic                 own_op, own_frame, own_wr;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_frame),
    .last    (last),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    own_port  = '0;
    own_data  = '0;
    own_addr  = '0;
    own_sub   = '0;
    own_op    = 1'b0;
    own_frame = 1'b0;
    own_wr    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == 3'(i)) begin
        own_port  = req_port[SC_PORT_W*i +: SC_PORT_W];
        own_data  = req_data[SC_DATA_W*i +: SC_DATA_W];
        own_addr  = req_addr[SC_DATA_W*i +: SC_DATA_W];
        own_sub   = req_subaddr[SC_DATA_W*i +: SC_DATA_W];
        own_op    = req_op[i];
        own_frame = req_frame[i];
        own_wr    = req_wr[i];
      end
    end
  end

  // Ack beats both abort and timeout when they coincide.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!flash_sc_ack && gnt_vld) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (flash_sc_ack)                 state_nxt = ST_ACK;
        else if (!own_frame)              state_nxt = ST_GAP;
        else if (cnt == 32'(TMO_CYC - 1)) state_nxt = ST_TMO;
      end
      ST_ACK:  if (!flash_sc_ack && !own_frame) state_nxt = ST_GAP;
      ST_TMO:  if (!own_frame) state_nxt = ST_GAP;
      ST_GAP:  if (cnt == 32'(GAP_CYC - 1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ack          = '0;
    rply_data        = '0;
    rply_error       = '0;
    flash_sc_port    = '0;
    flash_sc_data    = '0;
    flash_sc_addr    = '0;
    flash_sc_subaddr = '0;
    flash_sc_op      = 1'b0;
    flash_sc_frame   = 1'b0;
    flash_sc_wr      = 1'b0;
    if (state == ST_BUSY || state == ST_ACK || state == ST_TMO) begin
      flash_sc_port    = own_port;
      flash_sc_data    = own_data;
      flash_sc_addr    = own_addr;
      flash_sc_subaddr = own_sub;
      flash_sc_wr      = own_wr;
    end
    if (state == ST_BUSY || state == ST_ACK) begin
      flash_sc_op    = own_op;
      flash_sc_frame = own_frame;
      req_ack        = NREQ'(flash_sc_ack) << owner;
      rply_data      = flash_sc_rply_data;
      rply_error     = flash_sc_rply_error;
    end else if (state == ST_TMO) begin
      req_ack    = NREQ'(1) << owner;
      rply_error = SC_ERR_TMO;
    end
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      owner   <= '0;
      last    <= 3'(NREQ - 1);
      cnt     <= '0;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && state_nxt == ST_BUSY) begin
        owner <= gnt_idx;
        last  <= gnt_idx;
      end
      // One counter serves both the BUSY timeout and the GAP hold.
      if (state_nxt != state)
        cnt <= '0;
      else if (state == ST_BUSY || state == ST_GAP)
        cnt <= cnt + 32'd1;
      if (state == ST_BUSY && state_nxt == ST_TMO && tmo_cnt != 16'hFFFF)
        tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flash_sc_arbiter.sv
// tb_flash_sc_arbiter: directed self-checking bench for flash_sc_arbiter.
`default_nettype none

module tb_flash_sc_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] a_addr [3];
  logic [2:0]  frame_v;
  logic [2:0]  op_v;
  logic [2:0]  wr_v;

  logic [47:0] req_port;
  logic [95:0] req_data, req_addr, req_subaddr;
  logic [2:0]  req_ack;
  logic [31:0] rply_data, rply_error;
  logic [15:0] flash_sc_port;
  logic [31:0] flash_sc_data, flash_sc_addr, flash_sc_subaddr;
  logic        flash_sc_op, flash_sc_frame, flash_sc_wr;
  logic        flash_sc_ack;
  logic [31:0] flash_sc_rply_data, flash_sc_rply_error;
  logic [2:0]  owner;
  logic        busy;
  logic [15:0] tmo_cnt;

  assign req_port    = {16'h0102, 16'h0101, 16'h0100};
  assign req_data    = {32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
  assign req_addr    = {a_addr[2], a_addr[1], a_addr[0]};
  assign req_subaddr = {32'h5000_0002, 32'h5000_0001, 32'h5000_0000};

  flash_sc_arbiter #(.NREQ(3), .TMO_CYC(20), .GAP_CYC(2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_port            (req_port),
    .req_data            (req_data),
    .req_addr            (req_addr),
    .req_subaddr         (req_subaddr),
    .req_op              (op_v),
    .req_frame           (frame_v),
    .req_wr              (wr_v),
    .req_ack             (req_ack),
    .rply_data           (rply_data),
    .rply_error          (rply_error),
    .flash_sc_port       (flash_sc_port),
    .flash_sc_data       (flash_sc_data),
    .flash_sc_addr       (flash_sc_addr),
    .flash_sc_subaddr    (flash_sc_subaddr),
    .flash_sc_op         (flash_sc_op),
    .flash_sc_frame      (flash_sc_frame),
    .flash_sc_wr         (flash_sc_wr),
    .flash_sc_ack        (flash_sc_ack),
    .flash_sc_rply_data  (flash_sc_rply_data),
    .flash_sc_rply_error (flash_sc_rply_error),
    .owner               (owner),
    .busy                (busy),
    .tmo_cnt             (tmo_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_grant(input logic [1:0] e);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      tick();
      if (flash_sc_frame === 1'b1) got = 1'b1;
    end
    chk("grant_seen", 32'(got), 32'd1);
    chk("grant_owner", 32'(owner), 32'(e));
    chk("grant_addr", flash_sc_addr, a_addr[e]);
    chk("no_early_ack", 32'(req_ack), 32'd0);
  endtask

  task automatic complete(input logic [1:0] e, input logic [31:0] d);
    logic [2:0] oh;
    oh = 3'b001 << e;
    flash_sc_ack       = 1'b1;
    flash_sc_rply_data = d;
    tick();
    chk("ack_route", 32'(req_ack), 32'(oh));
    chk("ack_data", rply_data, d);
    chk("ack_err", rply_error, 32'd0);
    frame_v[e] = 1'b0;
    #1;
    chk("frame_drop_fwd", 32'(flash_sc_frame), 32'd0);
    chk("ack_hold", 32'(req_ack), 32'(oh));
    tick();
    flash_sc_ack = 1'b0;
    #1;
    chk("ack_release", 32'(req_ack), 32'd0);
    tick();
    chk("gap_busy", 32'(busy), 32'd1);
    chk("gap_frame", 32'(flash_sc_frame), 32'd0);
    chk("gap_rply", rply_data, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b1;
    frame_v             = 3'b000;
    op_v                = 3'b111;
    wr_v                = 3'b000;
    a_addr[0]           = 32'hA000_0000;
    a_addr[1]           = 32'h00FF_C000;
    a_addr[2]           = 32'hA000_0002;
    flash_sc_ack        = 1'b0;
    flash_sc_rply_data  = 32'd0;
    flash_sc_rply_error = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_frame", 32'(flash_sc_frame), 32'd0);
    chk("rst_tmo_cnt", 32'(tmo_cnt), 32'd0);
    chk("rst_ack", 32'(req_ack), 32'd0);

    // Single read from requester 1, ack three cycles after frame
    frame_v[1] = 1'b1;
    wait_grant(2'd1);
    chk("rd_op", 32'(flash_sc_op), 32'd1);
    chk("rd_port", 32'(flash_sc_port), 32'h0101);
    chk("rd_sub", flash_sc_subaddr, 32'h5000_0001);
    tick();
    tick();
    complete(2'd1, 32'h0AA0_8479);
    tick();
    chk("gap2_busy", 32'(busy), 32'd1);
    tick();
    chk("gap_end_idle", 32'(busy), 32'd0);

    // Simultaneous requests after reset: 0, 1, 2
    tick();
    do_reset();
    a_addr[1] = 32'hA000_0001;
    frame_v   = 3'b111;
    wait_grant(2'd0);
    complete(2'd0, 32'h1111_0000);
    wait_grant(2'd1);
    complete(2'd1, 32'h1111_0001);
    wait_grant(2'd2);
    complete(2'd2, 32'h1111_0002);

    // Fairness: req0 re-requests at once, req2 must be served first
    frame_v[0] = 1'b1;
    wait_grant(2'd0);
    frame_v[2] = 1'b1;
    complete(2'd0, 32'h2222_0000);
    frame_v[0] = 1'b1;
    wait_grant(2'd2);
    complete(2'd2, 32'h2222_0002);
    wait_grant(2'd0);
    complete(2'd0, 32'h2222_0010);

    // Timeout: flash never acks
    frame_v[1] = 1'b1;
    wait_grant(2'd1);
    repeat (19) tick();
    chk("tmo_pre_frame", 32'(flash_sc_frame), 32'd1);
    tick();
    chk("tmo_frame", 32'(flash_sc_frame), 32'd0);
    chk("tmo_op", 32'(flash_sc_op), 32'd0);
    chk("tmo_ack", 32'(req_ack), 32'b010);
    chk("tmo_err", rply_error, 32'h8000_0001);
    chk("tmo_data", rply_data, 32'd0);
    chk("tmo_cnt", 32'(tmo_cnt), 32'd1);
    frame_v[1] = 1'b0;
    tick();
    chk("tmo_gap_ack", 32'(req_ack), 32'd0);
    chk("tmo_gap_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("tmo_idle", 32'(busy), 32'd0);

    // Abort in BUSY followed by a late flash ack
    frame_v[1] = 1'b1;
    wait_grant(2'd1);
    frame_v[1] = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_ack", 32'(req_ack), 32'd0);
    tick();
    flash_sc_ack       = 1'b1;
    flash_sc_rply_data = 32'hDEAD_BEEF;
    frame_v[0]         = 1'b1;
    #1;
    chk("late_ack_blocked", 32'(req_ack), 32'd0);
    chk("late_rply_blocked", rply_data, 32'd0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("late_ack_hold_frame", 32'(flash_sc_frame), 32'd0);
      chk("late_ack_hold_ack", 32'(req_ack), 32'd0);
    end
    flash_sc_ack = 1'b0;
    tick();
    chk("post_late_frame", 32'(flash_sc_frame), 32'd1);
    chk("post_late_owner", 32'(owner), 32'd0);
    complete(2'd0, 32'h3333_0000);

    // Reset while in ACK
    frame_v[1] = 1'b1;
    wait_grant(2'd1);
    flash_sc_ack       = 1'b1;
    flash_sc_rply_data = 32'h4444_0001;
    tick();
    chk("pre_rst_ack", 32'(req_ack), 32'b010);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_frame", 32'(flash_sc_frame), 32'd0);
    chk("mid_rst_ack", 32'(req_ack), 32'd0);
    chk("mid_rst_owner", 32'(owner), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tmo_cnt", 32'(tmo_cnt), 32'd0);
    chk("mid_rst_addr", flash_sc_addr, 32'd0);
    chk("mid_rst_rply", rply_data, 32'd0);
    reset        = 1'b0;
    flash_sc_ack = 1'b0;
    frame_v[2]   = 1'b1;
    wait_grant(2'd1);
    complete(2'd1, 32'h5555_0001);
    wait_grant(2'd2);
    complete(2'd2, 32'h5555_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flash_sc_arbiter.md
# flash_sc_arbiter

Shares the single flash slow-control (SC) port among `NREQ` requesters: the boot-time IP/config reader, the global SC decoder, and future flash clients. Arbitration is round-robin and whole-transaction: a grant lasts from frame assertion through ack release. A per-transaction timeout keeps a silent flash controller from hanging the SC bus. The block sits between the requesters and the flash controller's SC slave.

## Interface
- `NREQ`, default 3: number of requesters, 2..8; index 0 is the boot reader.
- `TMO_CYC`, default 1_000_000: cycles without `flash_sc_ack` before timeout, 10 ms at 100 MHz.
- `GAP_CYC`, default 2: idle cycles forced between transactions, minimum 1.
- `clk`, in, 1: 100 MHz clock.
- `reset`, in, 1: asynchronous, active-high.
- `req_port`, in, 16*NREQ: SC port of each requester, packed with requester i at [16i+15:16i].
- `req_data`, `req_addr`, `req_subaddr`, in, 32*NREQ each: packed the same way.
- `req_op`, `req_frame`, `req_wr`, in, NREQ each: one bit per requester.
- `req_ack`, out, NREQ: ack routed to the owning requester only.
- `rply_data`, `rply_error`, out, 32 each: reply broadcast to all requesters; valid only while that requester's `req_ack` is high.
- `flash_sc_port`, out, 16; `flash_sc_data`, `flash_sc_addr`, `flash_sc_subaddr`, out, 32 each; `flash_sc_op`, `flash_sc_frame`, `flash_sc_wr`, out, 1 each: flash-side request.
- `flash_sc_ack`, in, 1; `flash_sc_rply_data`, `flash_sc_rply_error`, in, 32 each: flash-side reply.
- `owner`, out, 3: index of the current or last granted requester.
- `busy`, out, 1: high in any state other than IDLE.
- `tmo_cnt`, out, 16: saturating count of timeouts.

## Operation
- States: IDLE, BUSY, ACK, TMO, GAP.
- IDLE
  - Requests are eligible only when `flash_sc_ack` = 0.
  - Winner: the first i with `req_frame[i]` = 1, searching from `(last_owner+1) mod NREQ`. After reset the search starts at 0.
  - On a win: register `owner` = i, go to BUSY.
- BUSY
  - Flash outputs are driven from the owner's inputs through the registered `owner` mux.
  - `flash_sc_ack` = 1 → ACK.
  - Owner's `req_frame` = 0 before any ack is an abort → GAP; no ack is returned to the requester.
  - Timeout counter reaches `TMO_CYC` → TMO.
- ACK
  - `req_ack[owner]` = `flash_sc_ack`; `rply_data` and `rply_error` follow the flash inputs combinationally.
  - Flash request outputs stay routed, so the owner's own frame drop reaches the flash.
  - Exit to GAP when `flash_sc_ack` = 0 and owner `req_frame` = 0.
- TMO
  - `flash_sc_frame` and `flash_sc_op` are forced to 0.
  - `req_ack[owner]` = 1, `rply_data` = 0, `rply_error` = 32'h8000_0001.
  - `tmo_cnt` increments once on entry and saturates at 16'hFFFF.
  - Exit to GAP when owner `req_frame` = 0.
- GAP
  - All flash outputs are 0 and all `req_ack` are 0.
  - Hold for `GAP_CYC` cycles, then go to IDLE.
- Outside BUSY, ACK, and TMO:
  - Every flash output is 0.
  - `rply_data` and `rply_error` are 0.
- Flash acks arriving in IDLE or GAP (late acks after an abort) are never forwarded. IDLE waits for them to clear.
- Reset, asynchronous and taking effect at any time including mid-transaction:
  - State goes to IDLE; all outputs go to 0; `owner` = 0; `tmo_cnt` = 0; the round-robin pointer restarts at 0.
  - The flash sees `flash_sc_frame` fall immediately.

## Timing
- Grant latency: `req_frame` sampled high in IDLE → `flash_sc_frame` high on the next cycle (1 cycle).
- Ack forwarding is combinational from `flash_sc_ack` to `req_ack[owner]` (0 cycles).
- Timeout counter:
  - Clears on entry to BUSY.
  - Increments each BUSY cycle.
  - TMO is entered on the cycle after the count equals `TMO_CYC`-1, i.e. `TMO_CYC` BUSY cycles with no ack.
- Minimum transaction spacing: 1 IDLE + 1 BUSY + ack duration + `GAP_CYC` cycles.
- Simultaneous events:
  - If the owner drops `req_frame` in the same cycle `flash_sc_ack` rises, ack wins: the next state is ACK.
  - If ack arrives on the timeout cycle, ack wins over timeout.
- All state, `owner`, and counters are registered. Only the reply and ack routing is combinational.

## Structure
- The shared package `sru_sc_pkg` holds:
  - the state encoding;
  - the error code constant `SC_ERR_TMO` = 32'h8000_0001;
  - the SC bus field widths (port 16, data/addr 32).
- Sub-module `rr_pick`: a combinational round-robin priority picker, inputs `req[NREQ-1:0]` and `last[2:0]`, outputs `gnt_idx` and `gnt_vld`. It is reused by other SRU arbiters.
- Everything else is one module.

## Test plan
- Single read:
  - Stimulus: req1 frame with addr 32'h00FFC000; flash acks 3 cycles later with data 32'h0AA0_8479.
  - Response: `flash_sc_addr` = 32'h00FFC000 one cycle after frame; `req_ack[1]` high carrying that data; GAP of 2 cycles after release.
- Simultaneous requests:
  - Stimulus: req0, req1 and req2 raise frame together, after reset.
  - Response: grants in order 0, 1, 2; each `flash_sc_addr` matches its owner; no ack reaches a non-owner.
- Fairness:
  - Stimulus: req0 holds frame continuously while req2 requests once.
  - Response: req2 is granted right after req0's current transaction ends.
- Timeout:
  - Stimulus: `TMO_CYC` = 20, flash never acks.
  - Response: `flash_sc_frame` falls after 20 BUSY cycles; `req_ack` high with `rply_error` = 32'h8000_0001; `tmo_cnt` = 1.
- Abort with late ack:
  - Stimulus: owner drops frame in BUSY; flash acks 2 cycles later.
  - Response: no `req_ack`; the next grant waits until `flash_sc_ack` is low.
- Reset mid-ACK:
  - Stimulus: `reset` pulsed while in ACK.
  - Response: all outputs 0 immediately; `owner` = 0; the next grant starts the search from requester 0.
